// File: rtl/rr_bus_mux.sv
// Round-robin N:1 bus multiplexer with a single registered output stage and
// a valid/ready handshake toward the bus consumer.
module rr_bus_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N-1:0]       REQ,
  input  logic [N*WIDTH-1:0] DATA,
  input  logic               READY,
  output logic [N-1:0]       GNT,
  output logic [WIDTH-1:0]   Z,
  output logic [SELW-1:0]    SEL,
  output logic               VALID
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] win;
  logic [SELW-1:0] ptr_next;
  logic            load;
  logic            found;
  int              idx;

  // The output stage can take a new word when empty or being drained this edge.
  assign load = !VALID || READY;

  // Scan from the pointer upward with wrap; the first requester wins.
  // Reset gates the scan so no grant is ever shown while RST is high.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (!RST && load) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && REQ[idx] == 1'b1) begin
          found = 1'b1;
          win   = SELW'(idx);
        end
      end
    end
  end

  // Explicit compare against N-1 keeps the wrap correct for non-power-of-2 N.
  assign ptr_next = (int'(win) == N - 1) ? '0 : win + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign GNT[gi] = found && (win == SELW'(gi));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Z     <= '0;
      SEL   <= '0;
      VALID <= 1'b0;
      ptr   <= '0;
    end else if (load) begin
      if (found) begin
        Z     <= DATA[int'(win)*WIDTH +: WIDTH];
        SEL   <= win;
        VALID <= 1'b1;
        ptr   <= ptr_next;
      end else begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Self-checking bench for rr_bus_mux: directed vector table, hand sequences
// for reset corners, and a randomized run against a behavioural model.
module tb_rr_bus_mux;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] DATA = '0;
  logic        READY = 1'b1;
  logic [3:0]  GNT;
  logic [7:0]  Z;
  logic [1:0]  SEL;
  logic        VALID;

  logic [2:0]  req3 = '0;
  logic [23:0] data3 = 24'h222120;
  logic        ready3 = 1'b1;
  logic [2:0]  gnt3;
  logic [7:0]  z3;
  logic [1:0]  sel3;
  logic        valid3;

  int checks = 0;
  int errors = 0;

  rr_bus_mux #(.WIDTH(8), .N(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA), .READY(READY),
    .GNT(GNT), .Z(Z), .SEL(SEL), .VALID(VALID)
  );

  rr_bus_mux #(.WIDTH(8), .N(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ(req3), .DATA(data3), .READY(ready3),
    .GNT(gnt3), .Z(z3), .SEL(sel3), .VALID(valid3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Grant must be one-hot or zero; Z must not move while stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] z_prev = '0;
  always @(negedge CLK) begin
    chk("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
    if (RST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("z_stable_stall", 32'(Z), 32'(z_prev));
      stall_prev = VALID && !READY;
      z_prev     = Z;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  z;
    logic [1:0]  sel;
    logic        valid;
  } vec_t;

  vec_t vecs[15];

  // Behavioural model state
  int         m_ptr, m_sel;
  logic [7:0] m_z;
  logic       m_valid;
  logic       m_req[4];
  logic [7:0] m_data[4];
  int         m_last_win;

  localparam logic [31:0] BASE = 32'h13121110;
  localparam logic [31:0] ALT  = 32'h135A1110;

  initial begin
    vecs[0]  = '{4'hF, 1'b1, BASE, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[1]  = '{4'hF, 1'b1, BASE, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[2]  = '{4'hF, 1'b1, BASE, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[3]  = '{4'hF, 1'b1, BASE, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[4]  = '{4'hF, 1'b1, BASE, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[5]  = '{4'hF, 1'b1, BASE, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[6]  = '{4'hF, 1'b0, BASE, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[7]  = '{4'hF, 1'b0, BASE, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[8]  = '{4'hF, 1'b0, BASE, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[9]  = '{4'hF, 1'b1, BASE, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[10] = '{4'h3, 1'b1, BASE, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[11] = '{4'h3, 1'b1, BASE, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[12] = '{4'h0, 1'b1, BASE, 4'b0000, 8'h11, 2'd1, 1'b0};
    vecs[13] = '{4'h4, 1'b1, ALT,  4'b0100, 8'h5A, 2'd2, 1'b1};
    vecs[14] = '{4'h0, 1'b1, ALT,  4'b0000, 8'h5A, 2'd2, 1'b0};

    // Reset held for two cycles with all sources requesting
    RST = 1'b1; REQ = 4'hF; READY = 1'b1; DATA = BASE;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("rst_z", 32'(Z), 0);
      chk("rst_valid", 32'(VALID), 0);
      chk("rst_sel", 32'(SEL), 0);
      chk("rst_gnt", 32'(GNT), 0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;

    // Directed table: round-robin, backpressure, wrap/skip, single source
    for (int i = 0; i < 15; i++) begin
      REQ = vecs[i].req; READY = vecs[i].rdy; DATA = vecs[i].data;
      @(negedge CLK);
      chk($sformatf("vec%0d_gnt", i), 32'(GNT), 32'(vecs[i].gnt));
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_z", i), 32'(Z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_sel", i), 32'(SEL), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_valid", i), 32'(VALID), 32'(vecs[i].valid));
    end

    // N=3 rotation wraps from 2 back to 0
    req3 = 3'b111; ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("n3_sel%0d", i), 32'(sel3), 32'(i % 3));
      chk($sformatf("n3_z%0d", i), 32'(z3), 32'(8'h20 + (i % 3)));
    end
    req3 = '0;

    // Reset asserted between edges while a stalled word is held
    REQ = 4'b0100; READY = 1'b1; DATA = BASE;
    @(posedge CLK); #1;
    chk("mid_pre_z", 32'(Z), 32'h12);
    chk("mid_pre_valid", 32'(VALID), 1);
    REQ = 4'hF; READY = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("mid_async_z", 32'(Z), 0);
    chk("mid_async_valid", 32'(VALID), 0);
    chk("mid_async_gnt", 32'(GNT), 0);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("mid_held_valid", 32'(VALID), 0);
    RST = 1'b0; READY = 1'b1;
    @(negedge CLK);
    chk("mid_restart_gnt", 32'(GNT), 32'b0001);
    @(posedge CLK); #1;
    chk("mid_restart_z", 32'(Z), 32'h10);
    chk("mid_restart_sel", 32'(SEL), 0);

    // Randomized run against the model, from a fresh reset
    RST = 1'b1; REQ = '0;
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    m_ptr = 0; m_sel = 0; m_z = '0; m_valid = 1'b0; m_last_win = -1;
    for (int i = 0; i < 4; i++) begin m_req[i] = 1'b0; m_data[i] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      int         w;
      logic       ld;
      logic [3:0] exp_gnt;
      // Sources hold REQ/DATA until granted, otherwise pick fresh values
      for (int i = 0; i < 4; i++) begin
        if (!m_req[i] || m_last_win == i) begin
          m_req[i]  = ($urandom_range(0, 2) != 0);
          m_data[i] = 8'($urandom);
        end
        REQ[i] = m_req[i];
        DATA[i*8 +: 8] = m_data[i];
      end
      READY = ($urandom_range(0, 3) != 0);
      ld = !m_valid || READY;
      // Winner: lowest requester at or above ptr, else lowest requester overall
      w = -1;
      if (ld) begin
        for (int c = 3; c >= 0; c--) if (m_req[c] && c >= m_ptr) w = c;
        if (w < 0) for (int c = 3; c >= 0; c--) if (m_req[c]) w = c;
      end
      exp_gnt = (w >= 0) ? 4'(1 << w) : 4'b0;
      @(negedge CLK);
      chk($sformatf("rnd%0d_gnt", cyc), 32'(GNT), 32'(exp_gnt));
      @(posedge CLK);
      m_last_win = w;
      if (ld) begin
        if (w >= 0) begin
          m_z = m_data[w]; m_sel = w; m_valid = 1'b1; m_ptr = (w + 1) % 4;
        end else begin
          m_valid = 1'b0;
        end
      end
      #1;
      chk($sformatf("rnd%0d_z", cyc), 32'(Z), 32'(m_z));
      chk($sformatf("rnd%0d_sel", cyc), 32'(SEL), 32'(m_sel));
      chk($sformatf("rnd%0d_valid", cyc), 32'(VALID), 32'(m_valid));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised successor to the 8-bit 2:1 data-bus mux.
- Selects one of N requesting sources onto the CPU internal data bus using round-robin arbitration.
- Registers the selected word into a single-entry output stage with a valid/ready handshake.
- Sits between register-file/ALU/memory read ports and the bus consumer (accumulator/IR/MAR load logic).

Parameters:
- WIDTH, 8, data width of each source and of the output word.
- N, 4, number of source channels; legal range 1..16.
- SELW, $clog2(N) (minimum 1), derived localparam; width of the SEL output. Never overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  N  per-channel request; bit i high means DATA for channel i is valid.
- DATA  input  N*WIDTH  packed source words; channel i occupies [i*WIDTH +: WIDTH].
- READY  input  1  downstream accepts Z on any edge where VALID && READY.
- GNT  output  N  one-hot, combinational; bit i high means channel i's DATA is captured at this edge.
- Z  output  WIDTH  registered selected word.
- SEL  output  SELW  registered index of the channel that produced Z.
- VALID  output  1  Z/SEL hold an unconsumed word.

Behaviour:
- Reset (asynchronous, RST high):
  - Z=0, SEL=0, VALID=0, round-robin pointer PTR=0.
  - GNT=0 while RST is high.
  - Any word in flight is discarded; no GNT is issued during reset.
- Load enable: LOAD = !VALID || READY. A stalled output (VALID && !READY) gives LOAD=0.
- Arbitration, combinational, evaluated only when LOAD=1:
  - Scan channels PTR, PTR+1, …, N-1, 0, …, PTR-1.
  - The first channel with REQ high wins; GNT[win]=1 and all other GNT bits are 0.
  - With LOAD=0 or REQ=0, GNT=0.
- Clock edge with LOAD=1 and a winner:
  - Z<=DATA[win], SEL<=win, VALID<=1.
  - PTR<=win+1, wrapping from N-1 to 0 (this also holds for non-power-of-2 N).
- Clock edge with LOAD=1 and no REQ: VALID<=0; Z, SEL and PTR hold their values.
- Clock edge with LOAD=0: Z, SEL, VALID and PTR all hold.
- Handshake and throughput:
  - A word loaded at edge k is visible with VALID=1 after edge k (1-cycle latency).
  - It is consumed at the first edge where VALID && READY.
  - Consume and reload happen on the same edge, so throughput is 1 word/cycle with READY held high.
- Source rule: a source keeps REQ and DATA stable until it sees its GNT bit high at a clock edge. It may deassert REQ on the following cycle.
- Fairness: with all REQ held high and READY=1, grants rotate 0,1,…,N-1,0,… with no channel skipped.
- N=1: the scan is trivial, PTR stays 0 and SEL stays 0.
- No X propagation: if REQ is X or out of range, the output stage never loads X. Sim assertion: GNT is $onehot0.
- Z does not change while VALID && !READY (bench assertion).

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=4'b1111. Expect Z=0, VALID=0, SEL=0, GNT=0 throughout. After release, the first grant is GNT=4'b0001.
- Single source: N=4, WIDTH=8, REQ=4'b0100, DATA[2]=8'h5A, READY=1. Expect GNT=4'b0100, then Z=8'h5A, SEL=2, VALID=1 the next cycle. The following cycle, after REQ is dropped, VALID=0.
- Round-robin: REQ=4'b1111, DATA channel i = 8'h10+i, READY=1. Expect Z sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10 on consecutive cycles.
- Backpressure: load Z=8'h11 (SEL=1), then hold READY=0 for 3 cycles with REQ=4'b1111. Expect GNT=0, Z=8'h11, VALID=1 held. On the cycle READY=1, GNT=4'b0100 and Z=8'h12 on the next edge.
- Wrap and skip: PTR=3, REQ=4'b0011. Expect win=0 (wrap past 3), then PTR=1 and the next grant goes to channel 1. With N=3, REQ=3'b111, expect SEL sequence 0,1,2,0.
- Reset mid-operation: VALID=1, Z=8'h12, READY=0, then assert RST asynchronously between edges. Expect Z=0 and VALID=0 immediately (before the next edge), and PTR restarts at 0.
